multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I load/store/ALU datapath. It decodes `opcode`/`funct3`/`funct7` and steps each instruction through FETCH, DECODE, EXEC, MEM and WB. At each step it drives the datapath control strobes, a PC-advance enable and an instruction-register load. It waits on a data-memory ready handshake with a timeout, traps on illegal encodings, and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Multi-cycle sequencer for an RV32I load/store/ALU datapath. Each instruction
// is stepped through FETCH, DECODE, EXEC, MEM (loads/stores only) and WB. The
// datapath strobes are decoded from the registered state and the instruction
// class, alu_src and alu_cc latched in DECODE.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   run                 : level enable; sampled only at instruction boundaries
//   opcode/funct3/funct7: instruction fields, valid from DECODE onward
//   mem_ready           : data-memory completion for the current MEM access
//   ir_load             : latch the instruction register (FETCH)
//   pc_en               : advance PC by 4 (last cycle of a retiring instruction)
//   reg_write, mem2reg, alu_src, mem_write, mem_read, alu_cc : datapath controls
//   busy                : sequencer is inside an instruction
//   trap, trap_cause    : sticky fault flag; 01 illegal encoding, 10 mem timeout
//   retired             : wrapping count of pc_en cycles
//   dbg_state           : current FSM state encoding
//
// Memory handshake: while in MEM the controller holds mem_read (LOAD) or
// mem_write (STORE) high every cycle. The access completes in the first cycle
// mem_ready is sampled high; mem_ready in any other state is ignored. If
// mem_ready is still low on the MEM_TIMEOUT-th MEM cycle the sequencer traps,
// unless mem_ready is high in that same cycle, which completes the access.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int ALU_CC_W    = 4,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic                mem_ready,
    output logic                ir_load,
    output logic                pc_en,
    output logic                reg_write,
    output logic                mem2reg,
    output logic                alu_src,
    output logic                mem_write,
    output logic                mem_read,
    output logic [ALU_CC_W-1:0] alu_cc,
    output logic                busy,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [CNT_W-1:0]    retired,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        C_R     = 2'd0,
        C_I     = 2'd1,
        C_LOAD  = 2'd2,
        C_STORE = 2'd3
    } cls_t;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [3:0] CC_AND  = 4'b0000;
    localparam logic [3:0] CC_OR   = 4'b0001;
    localparam logic [3:0] CC_ADD  = 4'b0010;
    localparam logic [3:0] CC_XOR  = 4'b0011;
    localparam logic [3:0] CC_SLL  = 4'b0100;
    localparam logic [3:0] CC_SRL  = 4'b0101;
    localparam logic [3:0] CC_SUB  = 4'b0110;
    localparam logic [3:0] CC_SRA  = 4'b0111;
    localparam logic [3:0] CC_SLT  = 4'b1000;
    localparam logic [3:0] CC_SLTU = 4'b1001;

    // Wide enough to hold MEM_TIMEOUT-1 even when MEM_TIMEOUT is 1.
    localparam int          TMO_W    = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t                state;
    cls_t                  cls_q;
    logic                  src_q;
    logic [ALU_CC_W-1:0]   cc_q;
    logic                  trap_q;
    logic [1:0]            cause_q;
    logic [CNT_W-1:0]      retired_q;
    logic [TMO_W-1:0]      tmo_q;

    logic                  dec_legal;
    cls_t                  dec_cls;
    logic                  dec_src;
    logic [3:0]            dec_cc;

    // Default funct3 -> operation map shared by R and I forms.
    function automatic logic [3:0] f3_cc(input logic [2:0] f3);
        case (f3)
            3'b000:  f3_cc = CC_ADD;
            3'b001:  f3_cc = CC_SLL;
            3'b010:  f3_cc = CC_SLT;
            3'b011:  f3_cc = CC_SLTU;
            3'b100:  f3_cc = CC_XOR;
            3'b101:  f3_cc = CC_SRL;
            3'b110:  f3_cc = CC_OR;
            default: f3_cc = CC_AND;
        endcase
    endfunction

    // Instruction classification; only consumed in DECODE.
    always_comb begin
        dec_legal = 1'b0;
        dec_cls   = C_R;
        dec_src   = 1'b0;
        dec_cc    = CC_ADD;
        case (opcode)
            OPC_R: begin
                dec_cls = C_R;
                dec_src = 1'b0;
                if (funct7 == F7_ZERO) begin
                    dec_legal = 1'b1;
                    dec_cc    = f3_cc(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_cc    = CC_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_legal = 1'b1;
                    dec_cc    = CC_SRA;
                end
            end
            OPC_I: begin
                dec_cls = C_I;
                dec_src = 1'b1;
                dec_cc  = f3_cc(funct3);
                case (funct3)
                    3'b001: dec_legal = (funct7 == F7_ZERO);
                    3'b101: begin
                        dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                        if (funct7 == F7_ALT) begin
                            dec_cc = CC_SRA;
                        end
                    end
                    // funct3 000 is ADDI regardless of funct7 (no SUBI).
                    default: dec_legal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_cls   = C_LOAD;
                dec_src   = 1'b1;
                dec_legal = (funct3 == 3'b010);
            end
            OPC_STORE: begin
                dec_cls   = C_STORE;
                dec_src   = 1'b1;
                dec_legal = (funct3 == 3'b010);
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cls_q     <= C_R;
            src_q     <= 1'b0;
            cc_q      <= '0;
            trap_q    <= 1'b0;
            cause_q   <= 2'b00;
            retired_q <= '0;
            tmo_q     <= '0;
        end else begin
            if (pc_en) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    if (dec_legal) begin
                        cls_q <= dec_cls;
                        src_q <= dec_src;
                        cc_q  <= ALU_CC_W'(dec_cc);
                        state <= S_EXEC;
                    end else begin
                        trap_q  <= 1'b1;
                        cause_q <= 2'b01;
                        state   <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    tmo_q <= '0;
                    if (cls_q == C_LOAD || cls_q == C_STORE) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    // Ready is checked before the timeout so that a response
                    // on the last allowed cycle still completes the access.
                    if (mem_ready) begin
                        if (cls_q == C_LOAD) begin
                            state <= S_WB;
                        end else begin
                            state <= run ? S_FETCH : S_IDLE;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        trap_q  <= 1'b1;
                        cause_q <= 2'b10;
                        state   <= S_TRAP;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                S_WB:    state <= run ? S_FETCH : S_IDLE;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes are decoded from state and latched fields. The only same-cycle
    // dependency on an input is the STORE pc_en, which must coincide with the
    // cycle in which memory accepts the write.
    always_comb begin
        ir_load   = 1'b0;
        pc_en     = 1'b0;
        reg_write = 1'b0;
        mem2reg   = 1'b0;
        alu_src   = 1'b0;
        alu_cc    = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        busy      = 1'b0;
        case (state)
            S_FETCH: begin
                busy    = 1'b1;
                ir_load = 1'b1;
            end
            S_DECODE: busy = 1'b1;
            S_EXEC: begin
                busy    = 1'b1;
                alu_src = src_q;
                alu_cc  = cc_q;
            end
            S_MEM: begin
                busy      = 1'b1;
                alu_src   = src_q;
                alu_cc    = cc_q;
                mem_read  = (cls_q == C_LOAD);
                mem_write = (cls_q == C_STORE);
                pc_en     = (cls_q == C_STORE) && mem_ready;
            end
            S_WB: begin
                busy      = 1'b1;
                alu_src   = src_q;
                alu_cc    = cc_q;
                reg_write = 1'b1;
                pc_en     = 1'b1;
                mem2reg   = (cls_q == C_LOAD);
            end
            default: ;
        endcase
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign retired    = retired_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Stimulus drives instructions in batches; each issued instruction pushes its
// expected observable record (latency from ir_load to pc_en or trap, strobe
// counts, held ALU controls, retired value) into exp_q. A monitor on the
// falling edge rebuilds the same record from DUT outputs and compares.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int CNT_W = 2;
    localparam int T     = 8;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             run;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             mem_ready;
    logic             ir_load, pc_en, reg_write, mem2reg, alu_src, mem_write, mem_read;
    logic [3:0]       alu_cc;
    logic             busy, trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] retired;
    logic [2:0]       dbg_state;

    multicycle_ctrl #(
        .ALU_CC_W   (4),
        .CNT_W      (CNT_W),
        .MEM_TIMEOUT(T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .mem_ready  (mem_ready),
        .ir_load    (ir_load),
        .pc_en      (pc_en),
        .reg_write  (reg_write),
        .mem2reg    (mem2reg),
        .alu_src    (alu_src),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .alu_cc     (alu_cc),
        .busy       (busy),
        .trap       (trap),
        .trap_cause (trap_cause),
        .retired    (retired),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard data ----------------
    typedef struct packed {
        logic             is_trap;
        logic [1:0]       cause;
        logic [7:0]       lat;
        logic [3:0]       cc;
        logic             src;
        logic [7:0]       n_rd;
        logic [7:0]       n_wr;
        logic [3:0]       n_rw;
        logic [3:0]       n_m2r;
        logic [CNT_W-1:0] ret;
        logic             alu_bad;
    } rec_t;
    localparam int RW = $bits(rec_t);

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [7:0] w;
    } instr_t;

    logic [RW-1:0]    exp_q[$];
    logic [CNT_W-1:0] ret_q[$];
    instr_t           stim_q[$];

    int compared   = 0;
    int mismatched = 0;
    int model_ret  = 0;
    bit model_trapped = 0;
    int cur_w = 0;
    int mcnt  = 0;

    // ---------------- reference model ----------------
    function automatic void ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7, output bit legal,
                                       output int cls, output logic [3:0] cc,
                                       output bit src);
        logic [3:0] base_cc [8];
        // ADD SLL SLT SLTU XOR SRL OR AND indexed by funct3
        base_cc = '{4'd2, 4'd4, 4'd8, 4'd9, 4'd3, 4'd5, 4'd1, 4'd0};
        legal = 0; cls = 0; cc = 4'd0; src = 0;
        if (op == OP_R) begin
            cls = 0; src = 0;
            if (f7 == 7'h00) begin legal = 1; cc = base_cc[f3]; end
            else if (f7 == 7'h20 && f3 == 3'd0) begin legal = 1; cc = 4'd6; end
            else if (f7 == 7'h20 && f3 == 3'd5) begin legal = 1; cc = 4'd7; end
        end else if (op == OP_I) begin
            cls = 1; src = 1;
            if (f3 == 3'd1)      legal = (f7 == 7'h00);
            else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
            else                 legal = 1;
            cc = (f3 == 3'd5 && f7 == 7'h20) ? 4'd7 : base_cc[f3];
        end else if (op == OP_LD || op == OP_ST) begin
            cls = (op == OP_LD) ? 2 : 3; src = 1; cc = 4'd2;
            legal = (f3 == 3'd2);
        end
        if (!legal) begin cc = 4'd0; src = 0; end
    endfunction

    task automatic add_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input int w);
        rec_t       e;
        bit         legal;
        int         cls;
        logic [3:0] cc;
        bit         src;
        instr_t     s;
        ref_decode(op, f3, f7, legal, cls, cc, src);
        e = '0;
        e.ret = CNT_W'(model_ret % (1 << CNT_W));
        if (!legal) begin
            e.is_trap = 1; e.cause = 2'b01; e.lat = 8'd2;
            model_trapped = 1;
        end else if (cls >= 2 && w >= T) begin
            e.is_trap = 1; e.cause = 2'b10; e.lat = 8'(3 + T);
            e.cc = cc; e.src = src;
            if (cls == 2) e.n_rd = 8'(T); else e.n_wr = 8'(T);
            model_trapped = 1;
        end else begin
            e.cc = cc; e.src = src;
            e.lat   = (cls < 2) ? 8'd3 : (cls == 3) ? 8'(3 + w) : 8'(4 + w);
            e.n_rd  = (cls == 2) ? 8'(w + 1) : 8'd0;
            e.n_wr  = (cls == 3) ? 8'(w + 1) : 8'd0;
            e.n_rw  = (cls == 3) ? 4'd0 : 4'd1;
            e.n_m2r = (cls == 2) ? 4'd1 : 4'd0;
            model_ret++;
        end
        s.op = op; s.f3 = f3; s.f7 = f7; s.w = 8'(w);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic add_random();
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        int r, w;
        r  = $urandom_range(0, 19);
        op = (r < 6) ? OP_R : (r < 11) ? OP_I : (r < 15) ? OP_LD :
             (r < 19) ? OP_ST : 7'($urandom_range(0, 127));
        f3 = 3'($urandom_range(0, 7));
        if ((op == OP_LD || op == OP_ST) && $urandom_range(0, 7) != 0) f3 = 3'd2;
        r  = $urandom_range(0, 9);
        f7 = (r < 6) ? 7'h00 : (r < 9) ? 7'h20 : 7'($urandom_range(0, 127));
        r  = $urandom_range(0, 15);
        w  = (r == 0) ? T : (r == 1) ? T - 1 : $urandom_range(0, 3);
        add_instr(op, f3, f7, w);
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 time unit after the rising edge; outputs read here are
    // those of the state just entered.
    task automatic step();
        instr_t s;
        @(posedge clk);
        #1;
        if (ir_load && stim_q.size() > 0) begin
            s      = stim_q.pop_front();
            opcode = s.op;
            funct3 = s.f3;
            funct7 = s.f7;
            cur_w  = int'(s.w);
            mcnt   = 0;
            if (stim_q.size() == 0) run = 1'b0;
        end
        if (mem_read || mem_write) begin
            mem_ready = (mcnt == cur_w);
            mcnt++;
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        exp_q.delete();
        stim_q.delete();
        ret_q.delete();
        step();
        reset = 1'b0;
        model_ret = 0;
        model_trapped = 0;
        step();
    endtask

    task automatic run_batch();
        int budget;
        run = 1'b1;
        budget = 0;
        while (!(stim_q.size() == 0 && exp_q.size() == 0 &&
                 (model_trapped ? trap : !busy)) && budget < 400) begin
            step();
            budget++;
        end
        if (budget >= 400) begin
            compared++; mismatched++;
            $display("FAIL batch_timeout: got busy=%0b trap=%0b pending=%0d, required batch to finish",
                     busy, trap, exp_q.size());
            model_trapped = 1;
            return;
        end
        if (model_trapped) begin
            run = 1'b1;
            repeat (4) step();
            run = 1'b0;
        end
        ret_q.push_back(CNT_W'(model_ret % (1 << CNT_W)));
        budget = 0;
        while (ret_q.size() != 0 && budget < 10) begin
            step();
            budget++;
        end
    endtask

    // ---------------- monitor ----------------
    bit         tracking = 0;
    bit         pend_rst = 0;
    bit         alu_bad  = 0;
    bit         chk_next = 0;
    bit         next_run = 0;
    int         cyc = 0;
    int         n_rd = 0, n_wr = 0, n_rw = 0, n_m2r = 0;
    logic [3:0] cap_cc = 4'd0;
    logic       cap_src = 1'b0;
    rec_t       got_r, exp_r;
    logic [CNT_W-1:0] exp_ret;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                tracking = 0;
                pend_rst = 1;
                chk_next = 0;
            end else begin
                if (pend_rst) begin
                    pend_rst = 0;
                    compared++;
                    if ({ir_load, pc_en, reg_write, mem2reg, alu_src, mem_write, mem_read,
                         alu_cc, busy, trap, trap_cause, retired} != '0) begin
                        mismatched++;
                        $display("FAIL reset_vals: got pc_en=%0b mem_write=%0b busy=%0b trap=%0b cause=%0b retired=%0d, required all 0",
                                 pc_en, mem_write, busy, trap, trap_cause, retired);
                    end
                end
                if (chk_next) begin
                    chk_next = 0;
                    compared++;
                    if (next_run && !ir_load) begin
                        mismatched++;
                        $display("FAIL b2b_fetch: got ir_load=0, required 1 the cycle after pc_en");
                    end else if (!next_run && busy) begin
                        mismatched++;
                        $display("FAIL stop_idle: got busy=1, required 0 after pc_en with run low");
                    end
                end
                if (ir_load) begin
                    tracking = 1; cyc = 0; alu_bad = 0;
                    n_rd = 0; n_wr = 0; n_rw = 0; n_m2r = 0;
                    cap_cc = 4'd0; cap_src = 1'b0;
                end else if (tracking) begin
                    cyc++;
                end
                if (tracking) begin
                    n_rd  += int'(mem_read);
                    n_wr  += int'(mem_write);
                    n_rw  += int'(reg_write);
                    n_m2r += int'(mem2reg);
                    if (!trap) begin
                        if (cyc < 2) begin
                            if (alu_cc != 4'd0 || alu_src) alu_bad = 1;
                        end else if (cyc == 2) begin
                            cap_cc = alu_cc; cap_src = alu_src;
                        end else if (alu_cc != cap_cc || alu_src != cap_src) begin
                            alu_bad = 1;
                        end
                    end
                    if (pc_en || trap) begin
                        got_r = '0;
                        got_r.is_trap = trap;
                        got_r.cause   = trap_cause;
                        got_r.lat     = 8'(cyc);
                        got_r.cc      = cap_cc;
                        got_r.src     = cap_src;
                        got_r.n_rd    = 8'(n_rd);
                        got_r.n_wr    = 8'(n_wr);
                        got_r.n_rw    = 4'(n_rw);
                        got_r.n_m2r   = 4'(n_m2r);
                        got_r.ret     = retired;
                        got_r.alu_bad = alu_bad;
                        compared++;
                        if (exp_q.size() == 0) begin
                            mismatched++;
                            $display("FAIL instr_rec: got %h, required no instruction outstanding", got_r);
                        end else begin
                            exp_r = exp_q.pop_front();
                            if (got_r !== exp_r) begin
                                mismatched++;
                                $display("FAIL instr_rec: got trap=%0b cause=%0b lat=%0d cc=%0h src=%0b rd=%0d wr=%0d rw=%0d m2r=%0d ret=%0d alu_bad=%0b required trap=%0b cause=%0b lat=%0d cc=%0h src=%0b rd=%0d wr=%0d rw=%0d m2r=%0d ret=%0d alu_bad=%0b",
                                         got_r.is_trap, got_r.cause, got_r.lat, got_r.cc, got_r.src, got_r.n_rd, got_r.n_wr, got_r.n_rw, got_r.n_m2r, got_r.ret, got_r.alu_bad,
                                         exp_r.is_trap, exp_r.cause, exp_r.lat, exp_r.cc, exp_r.src, exp_r.n_rd, exp_r.n_wr, exp_r.n_rw, exp_r.n_m2r, exp_r.ret, exp_r.alu_bad);
                            end
                        end
                        if (pc_en && !trap) begin
                            chk_next = 1;
                            next_run = run;
                        end
                        tracking = 0;
                    end else if (cyc > 60) begin
                        compared++; mismatched++;
                        $display("FAIL instr_stuck: got no pc_en/trap after %0d cycles, required completion", cyc);
                        tracking = 0;
                    end
                end else if (trap) begin
                    compared++;
                    if (busy || ir_load || pc_en || reg_write || mem2reg || alu_src ||
                        mem_write || mem_read || alu_cc != 4'd0) begin
                        mismatched++;
                        $display("FAIL trap_hold: got busy=%0b ir_load=%0b strobes=%0b%0b%0b%0b%0b%0b cc=%0h, required all 0",
                                 busy, ir_load, pc_en, reg_write, mem2reg, alu_src, mem_write, mem_read, alu_cc);
                    end
                end
                if (!tracking && !busy && ret_q.size() > 0) begin
                    exp_ret = ret_q.pop_front();
                    compared++;
                    if (retired !== exp_ret) begin
                        mismatched++;
                        $display("FAIL retired_count: got %0d, required %0d", retired, exp_ret);
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int n, budget;
        reset = 1'b1; run = 1'b0; opcode = '0; funct3 = '0; funct7 = '0; mem_ready = 1'b0;
        do_reset();

        // ADD then SUB back to back
        add_instr(OP_R, 3'd0, 7'h00, 0);
        add_instr(OP_R, 3'd0, 7'h20, 0);
        run_batch();
        // LW with three wait states, SW ready at once
        add_instr(OP_LD, 3'd2, 7'h00, 3);
        run_batch();
        add_instr(OP_ST, 3'd2, 7'h00, 0);
        run_batch();
        // Ready on the last allowed MEM cycle completes the access
        add_instr(OP_LD, 3'd2, 7'h00, T - 1);
        add_instr(OP_ST, 3'd2, 7'h11, T - 1);
        run_batch();
        // Timeout trap
        add_instr(OP_LD, 3'd2, 7'h00, T);
        run_batch();
        do_reset();
        // Illegal encodings, each from reset
        add_instr(7'b1100011, 3'd0, 7'h00, 0);
        run_batch();
        do_reset();
        add_instr(OP_R, 3'd7, 7'h20, 0);
        run_batch();
        do_reset();
        add_instr(OP_LD, 3'd0, 7'h00, 0);
        run_batch();
        do_reset();
        // I-type corner encodings
        add_instr(OP_I, 3'd0, 7'h20, 0);
        add_instr(OP_I, 3'd5, 7'h20, 0);
        add_instr(OP_I, 3'd6, 7'h7f, 0);
        run_batch();
        // Counter wrap: five retirements from reset leave 1 in a 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) add_instr(OP_I, 3'd4, 7'h00, 0);
        run_batch();
        // Reset in the middle of a store with mem_write high
        add_instr(OP_ST, 3'd2, 7'h00, 5);
        run = 1'b1;
        budget = 0;
        while (!(mem_write && mcnt >= 2) && budget < 50) begin
            step();
            budget++;
        end
        if (budget >= 50) begin
            compared++; mismatched++;
            $display("FAIL mid_mem_reset: got mem_write=%0b, required store to reach MEM", mem_write);
        end
        do_reset();

        // Randomized batches
        for (int b = 0; b < 80; b++) begin
            if (model_trapped || $urandom_range(0, 3) == 0) do_reset();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                add_random();
                if (model_trapped) break;
            end
            run_batch();
        end

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
